// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store initiator with sub-word read-modify-write stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned requests; otherwise low address bits are forced aligned.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_MERGE, WR, ERR} state_t;
  state_t state, nxt;
  logic [31:0] addr_q, merge_q, a_al, lane, ld, mask, merged;
  logic [1:0]  size_q;
  logic        signed_q, accept;
  logic [4:0]  sh;
  assign accept = req_valid && req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
  assign mis = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
  assign a_al = req_addr;
`else
  assign a_al = req_size == 2'b00 ? req_addr :
                req_size == 2'b01 ? {req_addr[31:1], 1'b0} : {req_addr[31:2], 2'b00};
`endif
  // Aligned accesses make the byte shift cover half and word lanes too.
  assign sh     = {addr_q[1:0], 3'b000};
  assign lane   = mem_rdata >> sh;
  assign ld     = size_q == 2'b00 ? {{24{signed_q & lane[7]}}, lane[7:0]} :
                  size_q == 2'b01 ? {{16{signed_q & lane[15]}}, lane[15:0]} : mem_rdata;
  assign mask   = size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff;
  assign merged = (mem_rdata & ~(mask << sh)) | ((merge_q & mask) << sh);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (accept) nxt = !req_write ? RD : req_size[1] ? WR : RMW_RD;
      RD:        nxt = RD_WAIT;
      RMW_RD:    nxt = RMW_MERGE;
      RMW_MERGE: nxt = WR;
      default:   nxt = IDLE;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if (state == IDLE && accept && mis) nxt = ERR;
`endif
  end
  always_comb begin
    req_ready = state == IDLE;
    mem_read  = state == RD || state == RMW_RD;
    mem_write = state == WR;
  end
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = merge_q;
  // merge_q holds the store data from accept and is overwritten with the merged word.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q     <= '0;
      merge_q    <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= state == RD_WAIT || state == WR || state == ERR;
      if (state == RD_WAIT) resp_rdata <= ld;
      else if (state == WR || state == ERR) resp_rdata <= '0;
      if (accept) begin
        addr_q   <= a_al;
        merge_q  <= req_wdata;
        size_q   <= req_size;
        signed_q <= req_signed;
      end
      if (state == RMW_MERGE) merge_q <= merged;
    end
`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) resp_err <= 1'b0;
    else resp_err <= state == ERR;
`else
  assign resp_err = 1'b0;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b1, req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] rd; logic err; int due;} exp_t;
  exp_t q[$];
  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, compares = 0, fails = 0;
  logic [31:0] last_wa = '0, last_wd = '0, last_rdata = '0;
  logic acc_with_resp = 1'b0;
  function automatic logic [31:0] word_at(input logic [5:0] a);
    logic [5:0] b = {a[5:2], 2'b00};
    return {mem[b + 6'd3], mem[b + 6'd2], mem[b + 6'd1], mem[b]};
  endfunction
  // Memory: one-cycle registered read, write at the edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read) begin
      mem_rdata <= word_at(mem_addr[5:0]);
      rd_cnt = rd_cnt + 1;
    end
    if (mem_write) begin
      for (int i = 0; i < 4; i++) mem[{mem_addr[5:2], 2'b00} + 6'(i)] = mem_wdata[8*i +: 8];
      wr_cnt = wr_cnt + 1;
      last_wa = mem_addr;
      last_wd = mem_wdata;
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic err, output int lat);
    int n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    int ai = int'(a[5:0]);
    rd = '0;
    err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (ai % n != 0) begin
      err = 1'b1;
      lat = 1;
      return;
    end
`else
    ai = ai - ai % n;
`endif
    if (w) begin
      for (int i = 0; i < n; i++) ref_mem[(ai + i) % 64] = d[8*i +: 8];
      lat = n == 4 ? 1 : 3;
    end else begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[(ai + i) % 64];
      if (sg && n < 4 && rd[8*n-1]) rd = rd | (32'hffff_ffff << (8*n));
      lat = 2;
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    check("strobe_excl", {31'b0, mem_read & mem_write}, 32'd0);
    if (rst_n && resp_valid) begin
      if (q.size() == 0) check("spurious_resp", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("resp_rdata", resp_rdata, e.rd);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        check("resp_latency", cyc, e.due);
        last_rdata = resp_rdata;
      end
    end
  end
  task automatic issue(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int lat, t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    while (!req_ready && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc_with_resp = resp_valid;
    model(w, sz, sg, a, d, e.rd, e.err, lat);
    e.due = cyc + 1 + lat;
    q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || !req_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      check("resp_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask
  task automatic check_reset_outputs(input string nm);
    check({nm, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({nm, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({nm, "_resp_rdata"}, resp_rdata, 32'd0);
    check({nm, "_resp_err"}, {31'b0, resp_err}, 32'd0);
    check({nm, "_mem_strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
    check({nm, "_mem_addr"}, mem_addr, 32'd0);
    check({nm, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int r0, w0;
    logic [63:0] pre = 64'hFF0000FF_CC00FFAA;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem[i] = pre[8*i +: 8];
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    #2 rst_n = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    req_valid = 1'b0;
    rst_n = 1'b1;
    r0 = rd_cnt;
    issue(0, 2'd2, 0, 32'd0, 32'd0); wait_idle();
    check("lw0", last_rdata, 32'hCC00FFAA);
    check("lw0_read_cycles", rd_cnt - r0, 32'd1);
    issue(0, 2'd0, 1, 32'd0, 32'd0); wait_idle(); check("lb0", last_rdata, 32'hFFFFFFAA);
    issue(0, 2'd0, 0, 32'd0, 32'd0); wait_idle(); check("lbu0", last_rdata, 32'h000000AA);
    issue(0, 2'd1, 1, 32'd2, 32'd0); wait_idle(); check("lh2", last_rdata, 32'hFFFFCC00);
    issue(0, 2'd1, 0, 32'd6, 32'd0); wait_idle(); check("lhu6", last_rdata, 32'h0000FF00);
    // Abort a half store in its merge cycle: nothing may be written or answered.
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_addr = 32'd0; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_write", wr_cnt - w0, 32'd0);
    check("abort_word0", word_at(6'd0), 32'hCC00FFAA);
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1, 2'd0, 0, 32'd5, 32'h12345677); wait_idle();
    check("sb5_reads", rd_cnt - r0, 32'd1);
    check("sb5_write_cycles", wr_cnt - w0, 32'd1);
    check("sb5_wdata", last_wd, 32'hFF0077FF);
    check("sb5_waddr", last_wa, 32'd4);
    issue(0, 2'd2, 0, 32'd4, 32'd0); wait_idle(); check("lw4", last_rdata, 32'hFF0077FF);
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1, 2'd1, 0, 32'd1, 32'h00005678); wait_idle();
`ifdef LSU_MISALIGN_TRAP_EN
    check("sh1_no_strobes", (rd_cnt - r0) + (wr_cnt - w0), 32'd0);
    issue(0, 2'd2, 0, 32'd0, 32'd0); wait_idle(); check("sh1_mem_kept", last_rdata, 32'hCC00FFAA);
`else
    issue(0, 2'd2, 0, 32'd0, 32'd0); wait_idle(); check("sh1_lands_at0", last_rdata, 32'hCC005678);
`endif
    issue(1, 2'd2, 0, 32'd0, 32'h01020304);
    issue(0, 2'd2, 0, 32'd0, 32'd0);
    check("b2b_same_cycle", {31'b0, acc_with_resp}, 32'd1);
    wait_idle();
    check("b2b_lw0", last_rdata, 32'h01020304);
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 32'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    for (int i = 0; i < 64; i++) check("final_mem", {24'b0, mem[i]}, {24'b0, ref_mem[i]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the byte-addressed, little-endian data memory. It accepts one load or store request at a time from the MEM stage: byte, halfword or word, with signed or unsigned loads. It drives the memory's word-wide read and write strobes, absorbs the memory's one-cycle registered read latency, and builds sub-word stores as read-modify-write sequences. It returns a single-cycle response to the pipeline, and the pipeline stalls while `req_ready` is low.

## Interface
- No parameters. Address and data are fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high in IDLE. A request is accepted at a rising edge where `req_valid && req_ready && rst_n`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word. 11 is treated as word.
- `req_signed` in 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle completion pulse, registered.
- `resp_rdata` out 32: extended load data. Valid with `resp_valid`; 0 for stores.
- `resp_err` out 1: misaligned request, valid with `resp_valid`.
- `mem_addr` out 32: `{addr[31:2],2'b00}` taken from the captured address.
- `mem_wdata` out 32: merged store word.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_rdata` in 32: memory read data. Valid in the cycle after a cycle with `mem_read` high.

## Operation
- Acceptance captures address, write data, size, signed and write into internal registers.
- `mem_*` outputs are decoded from the state and the captured registers only. `mem_read` and `mem_write` are never high together.
- States and transitions:
  - IDLE: on accept, go to
    - ERR if the request is misaligned (with trap enabled);
    - WR for a word store;
    - RD for a load;
    - RMW_RD for a byte or half store.
  - RD: `mem_read=1`. Next state RD_WAIT.
  - RD_WAIT: select the lane of `mem_rdata`, extend it, register it to `resp_rdata` with `resp_valid=1`. Next state IDLE.
  - RMW_RD: `mem_read=1`. Next state RMW_MERGE.
  - RMW_MERGE: replace the addressed lane(s) of `mem_rdata` with the low byte or half of the captured data. Register the result as the merge word. Next state WR.
  - WR: `mem_write=1`, `mem_wdata` = merge word (word store: captured data). At the edge, `resp_valid=1`. Next state IDLE.
  - ERR: no memory access. `resp_valid=1`, `resp_err=1` at the edge. Next state IDLE.
- Lane selection, little-endian:
  - byte lane `addr[1:0]` covers bits `[8*addr[1:0]+7 : 8*addr[1:0]]`;
  - half lane `addr[1]` covers bits `[16*addr[1]+15 : 16*addr[1]]`.
- Misaligned means: half with `addr[0]=1`; word with `addr[1:0]!=0`.

## Timing
- Accept at edge k.
- Word store: `mem_write` during cycle k..k+1. The memory writes at k+1, and `resp_valid` is high after k+1.
- Load: `mem_read` during k..k+1. `mem_rdata` is valid during k+1..k+2, and `resp_valid` is high after k+2.
- Sub-word store: read during k..k+1, merge at k+2, write during k+2..k+3. `resp_valid` is high after k+3.
- Misaligned: `resp_valid`/`resp_err` high after k+1.
- `resp_valid` lasts exactly one cycle. A new request may be accepted in that same cycle, giving back-to-back operation with no bubble.
- Reset values: state IDLE; `resp_valid=0`, `resp_rdata=0`, `resp_err=0`; `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`; `req_ready=1`. Requests are ignored while `rst_n=0`.
- Reset mid-operation aborts the operation immediately:
  - `mem_write` drops asynchronously, so no write occurs at the next edge;
  - no response is produced for the aborted request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned requests go to ERR as described, with no memory access.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - the ERR state is not built and `resp_err` is tied 0;
  - low address bits below the access size are forced to zero;
  - the aligned access proceeds normally.

## Test plan
- Memory preload for all tests: bytes 0..7 = AA FF 00 CC FF 00 00 FF.
- Load word at address 0 -> `resp_rdata=0xCC00FFAA`, `resp_valid` 2 edges after accept, `mem_read` high exactly 1 cycle.
- Loads:
  - `lb` addr 0 -> 0xFFFFFFAA;
  - `lbu` addr 0 -> 0x000000AA;
  - `lh` addr 2 -> 0xFFFFCC00;
  - `lhu` addr 6 -> 0x0000FF00.
- `sb` addr 5, data 0x12345677 -> one read, then `mem_write` for 1 cycle with `mem_wdata=0xFF0077FF` at `mem_addr=4`. `resp_valid` 3 edges after accept. A following `lw` 4 returns 0xFF0077FF.
- Misaligned `sh` addr 1, trap enabled -> `resp_valid=1`, `resp_err=1` 1 edge after accept, no strobes. Trap disabled -> a half store lands at addr 0.
- `rst_n` pulled low during RMW_MERGE of `sh` addr 0 -> `mem_write` never high, word 0 stays 0xCC00FFAA, all outputs at their reset values.
- `sw` addr 0 data 0x01020304, then `lw` 0 presented while `resp_valid` is high -> accepted the same cycle, returns 0x01020304 2 edges later.
